reg_xfer_ctrl: RTL
==================

# reg_xfer_ctrl

Register-transfer controller that acts as the initiator side of the `reg_file` read/write port. It accepts one transfer command at a time over a valid/ready handshake: load immediate, move, exchange or clear. It sequences the `reg_r`/`reg_w` strobes, selects and write data cycle by cycle. It sits between instruction decode and `reg_file`, and is the only block driving the register-file port.

## Interface
Parameters:
- SEL_AL, 8'h00, select code for AL
- SEL_BL, 8'h01, select code for BL
- SEL_CL, 8'h02, select code for CL
- SEL_DL, 8'h03, select code for DL

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE with reset low; accept = cmd_valid & cmd_ready at rising edge
- cmd_op  in  2  00 LOAD (imm->dst), 01 MOV (src->dst), 10 XCHG (src<->dst), 11 CLR (0->dst)
- cmd_src  in  8  source select code (ignored by LOAD, CLR)
- cmd_dst  in  8  destination select code
- cmd_imm  in  8  immediate (LOAD only)
- done  out  1  one-cycle pulse at command completion
- err  out  1  one-cycle pulse with done when the command was rejected
- rd_data  out  8  last value captured from reg_r_line; holds between commands
- reg_r  out  1  read strobe to reg_file
- reg_r_select  out  8  read select
- reg_r_line  in  8  read data from reg_file, valid combinationally in the cycle reg_r is high
- reg_w  out  1  write strobe; reg_file writes at the rising edge ending a cycle with reg_w high
- reg_w_select  out  8  write select
- reg_w_line  out  8  write data

## Operation
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- Command fields (op, src, dst, imm) are latched on accept. Inputs are ignored afterwards until the next accept.
- Validation at accept:
  - dst must match one of the four SEL_* codes.
  - For MOV and XCHG, src must also match.
  - On failure: IDLE -> FIN, no strobes are issued, and err=1 with done.
- Valid command paths:
  - LOAD: IDLE -> WR_A -> FIN. In WR_A: reg_w=1, reg_w_select=dst, reg_w_line=imm.
  - CLR: same path as LOAD, with reg_w_line=8'h00.
  - MOV: IDLE -> RD_A -> WR_A -> FIN.
    - RD_A: reg_r=1, reg_r_select=src; tmp_a<=reg_r_line.
    - WR_A: reg_w=1, reg_w_select=dst, reg_w_line=tmp_a.
  - XCHG: IDLE -> RD_A -> RD_B -> WR_A -> WR_B -> FIN.
    - RD_A reads src into tmp_a.
    - RD_B reads dst into tmp_b.
    - WR_A writes tmp_a to dst.
    - WR_B writes tmp_b to src.
- FIN: done=1 (err as decided at accept). FIN -> IDLE unconditionally.
- rd_data is updated at every RD_* edge. After XCHG it holds the original dst value.
- Outside their active state: reg_r=0, reg_w=0, selects and reg_w_line = 8'h00. Consumers qualify selects and data with the strobes.
- reg_r and reg_w are never both high in the same cycle.
- src==dst is legal and fully sequenced: MOV rewrites the same value, and XCHG leaves the register unchanged.
- Reset:
  - Forces IDLE at the next edge, clears tmp_a, tmp_b and rd_data to 0, and drives all outputs low.
  - An in-flight command is abandoned without done.
  - An XCHG abandoned after WR_A leaves both registers holding the original src value. This is accepted behaviour.

## Timing
- Accept at edge E0. The first action cycle follows E0.
- done appears in cycle:
  - LOAD/CLR: E0+2
  - MOV: E0+3
  - XCHG: E0+5
  - rejected command: E0+1
- cmd_ready returns high in the cycle after FIN. Minimum command spacing is 3 cycles (LOAD/CLR), 4 (MOV), 6 (XCHG) and 2 (reject).
- A register written in WR_A/WR_B holds its new value from the edge ending that cycle.
- Reset values: cmd_ready=0 while reset is high, then 1. All other outputs are 0.

## Test plan
- Reset, then LOAD dst=SEL_AL imm=8'hAA -> single reg_w cycle with reg_w_line=8'hAA; done two cycles after accept; al=8'hAA.
- LOAD BL=8'hBB, then MOV src=BL dst=DL -> one reg_r cycle (sel BL) then one reg_w cycle (sel DL, line 8'hBB); dl=8'hBB; rd_data=8'hBB; done at E0+3.
- AL=8'h11, CL=8'h22; XCHG src=AL dst=CL -> strobe order: R(AL), R(CL), W(CL, 8'h11), W(AL, 8'h22); done at E0+5; rd_data=8'h22.
- CLR with dst=8'h07 (invalid) -> no strobes; done=1 and err=1 at E0+1; all registers unchanged.
- Hold cmd_valid high with a MOV during an XCHG -> cmd_ready low until after FIN; the MOV is accepted exactly once.
- Assert reset in WR_A of an XCHG (AL=8'h11, CL=8'h22) -> no done; outputs low next cycle; cl=8'h11, al=8'h11; a new LOAD after reset completes normally.

Source files
------------

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: initiator for the reg_file read/write port.
// Accepts one LOAD / MOV / XCHG / CLR command at a time. It then drives the
// reg_r / reg_w strobes, the selects and the write data, one cycle at a time.
module reg_xfer_ctrl #(
    parameter logic [7:0] SEL_AL = 8'h00,
    parameter logic [7:0] SEL_BL = 8'h01,
    parameter logic [7:0] SEL_CL = 8'h02,
    parameter logic [7:0] SEL_DL = 8'h03
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_src,
    input  logic [7:0] cmd_dst,
    input  logic [7:0] cmd_imm,
    output logic       done,
    output logic       err,
    output logic [7:0] rd_data,
    output logic       reg_r,
    output logic [7:0] reg_r_select,
    input  logic [7:0] reg_r_line,
    output logic       reg_w,
    output logic [7:0] reg_w_select,
    output logic [7:0] reg_w_line
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_WR_A = 3'd3;
    localparam logic [2:0] ST_WR_B = 3'd4;
    localparam logic [2:0] ST_FIN  = 3'd5;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOV  = 2'b01;
    localparam logic [1:0] OP_XCHG = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    logic [2:0] state_q, state_d;
    logic [1:0] op_q, op_d;
    logic [7:0] src_q, src_d;
    logic [7:0] dst_q, dst_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] tmp_a_q, tmp_a_d;
    logic [7:0] tmp_b_q, tmp_b_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       err_q, err_d;

    logic       accept;
    logic       uses_src;
    logic       cmd_ok;

    function automatic logic sel_ok(input logic [7:0] s);
        return (s == SEL_AL) || (s == SEL_BL) || (s == SEL_CL) || (s == SEL_DL);
    endfunction

    // Handshake and command validation; src only matters for MOV and XCHG.
    always_comb begin
        cmd_ready = (state_q == ST_IDLE) && !reset;
        accept    = cmd_valid && cmd_ready;
        uses_src  = (cmd_op == OP_MOV) || (cmd_op == OP_XCHG);
        cmd_ok    = sel_ok(cmd_dst) && (!uses_src || sel_ok(cmd_src));
    end

    // Next-state logic: command latch, sequencing and read-data capture.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_d     = imm_q;
        tmp_a_d   = tmp_a_q;
        tmp_b_d   = tmp_b_q;
        rd_data_d = rd_data_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = cmd_op;
                    src_d = cmd_src;
                    dst_d = cmd_dst;
                    imm_d = cmd_imm;
                    err_d = !cmd_ok;
                    if (!cmd_ok) begin
                        state_d = ST_FIN;
                    end else if ((cmd_op == OP_LOAD) || (cmd_op == OP_CLR)) begin
                        state_d = ST_WR_A;
                    end else begin
                        state_d = ST_RD_A;
                    end
                end
            end
            ST_RD_A: begin
                tmp_a_d   = reg_r_line;
                rd_data_d = reg_r_line;
                state_d   = (op_q == OP_XCHG) ? ST_RD_B : ST_WR_A;
            end
            ST_RD_B: begin
                tmp_b_d   = reg_r_line;
                rd_data_d = reg_r_line;
                state_d   = ST_WR_A;
            end
            ST_WR_A: begin
                state_d = (op_q == OP_XCHG) ? ST_WR_B : ST_FIN;
            end
            ST_WR_B: begin
                state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port drive: strobes, selects and data are only non-zero in their own state.
    always_comb begin
        reg_r        = 1'b0;
        reg_r_select = 8'h00;
        reg_w        = 1'b0;
        reg_w_select = 8'h00;
        reg_w_line   = 8'h00;
        done         = 1'b0;
        err          = 1'b0;
        case (state_q)
            ST_RD_A: begin
                reg_r        = 1'b1;
                reg_r_select = src_q;
            end
            ST_RD_B: begin
                reg_r        = 1'b1;
                reg_r_select = dst_q;
            end
            ST_WR_A: begin
                reg_w        = 1'b1;
                reg_w_select = dst_q;
                if (op_q == OP_LOAD) begin
                    reg_w_line = imm_q;
                end else if (op_q == OP_CLR) begin
                    reg_w_line = 8'h00;
                end else begin
                    reg_w_line = tmp_a_q;
                end
            end
            ST_WR_B: begin
                reg_w        = 1'b1;
                reg_w_select = src_q;
                reg_w_line   = tmp_b_q;
            end
            ST_FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: begin
            end
        endcase
    end

    assign rd_data = rd_data_q;

    // State registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LOAD;
            src_q     <= 8'h00;
            dst_q     <= 8'h00;
            imm_q     <= 8'h00;
            tmp_a_q   <= 8'h00;
            tmp_b_q   <= 8'h00;
            rd_data_q <= 8'h00;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_q     <= imm_d;
            tmp_a_q   <= tmp_a_d;
            tmp_b_q   <= tmp_b_d;
            rd_data_q <= rd_data_d;
            err_q     <= err_d;
        end
    end

endmodule
